// File: rtl/wb_pkg.sv
// Shared types for the flattened Wishbone round-robin arbiter.
package wb_pkg;

  localparam int unsigned WbXlen = 32;
  localparam int unsigned WbSelW = WbXlen / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_e;

  typedef struct packed {
    logic [WbXlen-1:0] adr;
    logic [WbSelW-1:0] sel;
    logic              we;
    logic [WbXlen-1:0] dat_w;
  } wb_req_t;

  // Index width that stays at least one bit for a single-entry arbiter.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping mod N.
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]            req_i,
  input  logic [idx_width(N)-1:0] ptr_i,
  output logic [N-1:0]            gnt_o,
  output logic [idx_width(N)-1:0] gnt_idx_o
);

  localparam int unsigned IdxW = idx_width(N);

  always_comb begin
    logic found;
    int   idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < int'(N); i++) begin
      idx = (int'(ptr_i) + i) % int'(N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_flat_arbiter.sv
// Round-robin merge of N flattened Wishbone masters onto one slave port.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out a stalled slave.
module wb_flat_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS*XLEN-1:0]   s_adr,
  input  logic [N_MASTERS*XLEN/8-1:0] s_sel,
  input  logic [N_MASTERS-1:0]        s_we,
  input  logic [N_MASTERS-1:0]        s_stb,
  input  logic [N_MASTERS*XLEN-1:0]   s_dat_w,
  output logic [XLEN-1:0]             s_dat_r,
  output logic [N_MASTERS-1:0]        s_ack,
  output logic [N_MASTERS-1:0]        s_err,
  output logic [XLEN-1:0]             m_adr,
  output logic [XLEN/8-1:0]           m_sel,
  output logic                        m_we,
  output logic [XLEN-1:0]             m_dat_w,
  output logic                        m_stb,
  input  logic [XLEN-1:0]             m_dat_r,
  input  logic                        m_ack
);

  localparam int unsigned SelW = XLEN / 8;
  localparam int unsigned IdxW = idx_width(N_MASTERS);

  if (XLEN != WbXlen) begin : g_bad_xlen
    $error("XLEN must match wb_pkg::WbXlen");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  wb_req_t               req_q, req_d;
  logic                  m_stb_q, m_stb_d;
  logic [N_MASTERS-1:0]  s_ack_q, s_ack_d;
  logic [N_MASTERS-1:0]  s_err_q, s_err_d;
  logic [XLEN-1:0]       s_dat_r_q, s_dat_r_d;

  logic [N_MASTERS-1:0]  gnt;
  logic [IdxW-1:0]       gnt_idx;
  wb_req_t               sel_req;
  logic                  timed_out;

  rr_arbiter #(
    .N (N_MASTERS)
  ) u_rr_arbiter (
    .req_i     (s_stb),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // AND-OR mux of the granted master's request fields.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (gnt[i]) begin
        sel_req.adr   = s_adr[i*XLEN +: XLEN];
        sel_req.sel   = s_sel[i*SelW +: SelW];
        sel_req.we    = s_we[i];
        sel_req.dat_w = s_dat_w[i*XLEN +: XLEN];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [$clog2(TIMEOUT)-1:0] cnt_q, cnt_d;

  assign timed_out = (cnt_q == ($clog2(TIMEOUT))'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ARB_REQ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    req_d     = req_q;
    m_stb_d   = m_stb_q;
    s_ack_d   = '0;
    s_err_d   = '0;
    s_dat_r_d = s_dat_r_q;
    case (state_q)
      ARB_IDLE: begin
        if (|s_stb) begin
          grant_d = gnt_idx;
          req_d   = sel_req;
          m_stb_d = 1'b1;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        // A late ack on the watchdog's final cycle still completes normally.
        if (m_ack) begin
          m_stb_d          = 1'b0;
          s_dat_r_d        = m_dat_r;
          s_ack_d[grant_q] = 1'b1;
          state_d          = ARB_RESP;
        end else if (timed_out) begin
          m_stb_d          = 1'b0;
          s_dat_r_d        = '0;
          s_err_d[grant_q] = 1'b1;
          state_d          = ARB_RESP;
        end
      end
      ARB_RESP: begin
        rr_ptr_d = (grant_q == IdxW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      req_q     <= '0;
      m_stb_q   <= 1'b0;
      s_ack_q   <= '0;
      s_err_q   <= '0;
      s_dat_r_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      req_q     <= req_d;
      m_stb_q   <= m_stb_d;
      s_ack_q   <= s_ack_d;
      s_err_q   <= s_err_d;
      s_dat_r_q <= s_dat_r_d;
    end
  end

  assign m_adr   = req_q.adr;
  assign m_sel   = req_q.sel;
  assign m_we    = req_q.we;
  assign m_dat_w = req_q.dat_w;
  assign m_stb   = m_stb_q;
  assign s_ack   = s_ack_q;
  assign s_err   = s_err_q;
  assign s_dat_r = s_dat_r_q;

endmodule

// File: tb/tb_wb_flat_arbiter.sv
// Directed bench for wb_flat_arbiter: a 2-master and a 4-master instance on one clock.
module tb_wb_flat_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  // Instance A: two masters
  logic [63:0] s_adr_a, s_dat_w_a;
  logic [7:0]  s_sel_a;
  logic [1:0]  s_we_a, s_stb_a, s_ack_a, s_err_a;
  logic [31:0] s_dat_r_a, m_adr_a, m_dat_w_a, m_dat_r_a;
  logic [3:0]  m_sel_a;
  logic        m_we_a, m_stb_a, m_ack_a, ack_a, zw_a;

  // Instance B: four masters
  logic [127:0] s_adr_b, s_dat_w_b;
  logic [15:0]  s_sel_b;
  logic [3:0]   s_we_b, s_stb_b, s_ack_b, s_err_b;
  logic [31:0]  s_dat_r_b, m_adr_b, m_dat_w_b, m_dat_r_b;
  logic [3:0]   m_sel_b;
  logic         m_we_b, m_stb_b, ack_b;

  logic ok;

  // zw_a turns slave A into a zero-wait slave that acks every strobe.
  assign m_ack_a = zw_a ? m_stb_a : ack_a;

  wb_flat_arbiter #(.XLEN(32), .N_MASTERS(2), .TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .s_adr(s_adr_a), .s_sel(s_sel_a), .s_we(s_we_a), .s_stb(s_stb_a), .s_dat_w(s_dat_w_a),
    .s_dat_r(s_dat_r_a), .s_ack(s_ack_a), .s_err(s_err_a),
    .m_adr(m_adr_a), .m_sel(m_sel_a), .m_we(m_we_a), .m_dat_w(m_dat_w_a), .m_stb(m_stb_a),
    .m_dat_r(m_dat_r_a), .m_ack(m_ack_a)
  );

  wb_flat_arbiter #(.XLEN(32), .N_MASTERS(4), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_adr(s_adr_b), .s_sel(s_sel_b), .s_we(s_we_b), .s_stb(s_stb_b), .s_dat_w(s_dat_w_b),
    .s_dat_r(s_dat_r_b), .s_ack(s_ack_b), .s_err(s_err_b),
    .m_adr(m_adr_b), .m_sel(m_sel_b), .m_we(m_we_b), .m_dat_w(m_dat_w_b), .m_stb(m_stb_b),
    .m_dat_r(m_dat_r_b), .m_ack(ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    s_adr_a = '0; s_dat_w_a = '0; s_sel_a = '0; s_we_a = '0; s_stb_a = '0;
    m_dat_r_a = '0; ack_a = 1'b0; zw_a = 1'b0;
    s_adr_b = '0; s_dat_w_b = '0; s_sel_b = '0; s_we_b = '0; s_stb_b = '0;
    m_dat_r_b = '0; ack_b = 1'b0;
    tick; tick;
    check("rst_m_stb_a", m_stb_a, 1'b0);
    check("rst_s_ack_a", s_ack_a, 2'b00);
    check("rst_s_err_a", s_err_a, 2'b00);
    check("rst_m_adr_a", m_adr_a, 32'h0);
    check("rst_s_dat_r_a", s_dat_r_a, 32'h0);
    check("rst_m_stb_b", m_stb_b, 1'b0);
    rst = 1'b0;

    // 1: single read, slave acks one cycle after m_stb rises
    s_adr_a[31:0] = 32'h100; s_stb_a = 2'b01;
    tick;
    check("t1_m_stb", m_stb_a, 1'b1);
    check("t1_m_adr", m_adr_a, 32'h100);
    check("t1_m_we", m_we_a, 1'b0);
    check("t1_no_early_ack", s_ack_a, 2'b00);
    tick;
    check("t1_m_stb_held", m_stb_a, 1'b1);
    ack_a = 1'b1; m_dat_r_a = 32'hDEADBEEF;
    tick;
    check("t1_s_ack", s_ack_a, 2'b01);
    check("t1_s_dat_r", s_dat_r_a, 32'hDEADBEEF);
    check("t1_m_stb_drop", m_stb_a, 1'b0);
    ack_a = 1'b0; s_stb_a = 2'b00;
    tick;
    check("t1_ack_pulse", s_ack_a, 2'b00);

    // 2: contention from reset with a zero-wait slave
    rst = 1'b1; tick; rst = 1'b0;
    s_adr_a = {32'hB0, 32'hA0}; s_stb_a = 2'b11; zw_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("t2_m_adr", m_adr_a, (k % 2 == 0) ? 32'hA0 : 32'hB0);
      tick;
      check("t2_s_ack", s_ack_a, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick;
      check("t2_ack_one_cycle", s_ack_a, 2'b00);
    end
    s_stb_a = 2'b00; zw_a = 1'b0;
    tick;

    // 3: write from master 2 of 4 with three wait states
    s_adr_b = {32'h3000, 32'h2000, 32'h1000, 32'h0};
    s_sel_b = 16'hF3FF;
    s_we_b = 4'b0100;
    s_dat_w_b = {32'h3333, 32'h0000ABCD, 32'h1111, 32'h0};
    s_stb_b = 4'b0100;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("t3_m_stb", m_stb_b, 1'b1);
      check("t3_m_adr", m_adr_b, 32'h2000);
      check("t3_m_sel", m_sel_b, 4'b0011);
      check("t3_m_we", m_we_b, 1'b1);
      check("t3_m_dat_w", m_dat_w_b, 32'h0000ABCD);
      check("t3_no_ack", s_ack_b, 4'b0000);
      if (i == 3) ack_b = 1'b1;
      tick;
    end
    check("t3_s_ack", s_ack_b, 4'b0100);
    check("t3_m_stb_drop", m_stb_b, 1'b0);
    ack_b = 1'b0; s_stb_b = 4'b0000;
    tick;
    check("t3_ack_pulse", s_ack_b, 4'b0000);

    // 4: reset mid-REQ; pointer is first moved to master 1
    zw_a = 1'b1; s_stb_a = 2'b01;
    tick; tick;
    s_stb_a = 2'b00;
    tick;
    zw_a = 1'b0; s_stb_a = 2'b11;
    tick;
    check("t4_grant1", m_adr_a, 32'hB0);
    tick;
    rst = 1'b1;
    tick;
    check("t4_m_stb_rst", m_stb_a, 1'b0);
    check("t4_m_adr_rst", m_adr_a, 32'h0);
    check("t4_s_ack_rst", s_ack_a, 2'b00);
    rst = 1'b0; s_stb_a = 2'b00; ack_a = 1'b1;
    tick;
    check("t4_stray_ack", s_ack_a, 2'b00);
    tick;
    check("t4_stray_ack2", s_ack_a, 2'b00);
    check("t4_no_err", s_err_a, 2'b00);
    ack_a = 1'b0; s_stb_a = 2'b11;
    tick;
    check("t4_regrant0", m_adr_a, 32'hA0);
    ack_a = 1'b1;
    tick;
    check("t4_ack0", s_ack_a, 2'b01);
    ack_a = 1'b0; s_stb_a = 2'b00;
    tick;

`ifdef WB_ARB_TIMEOUT_EN
    // 5: watchdog expires after 8 REQ cycles
    m_dat_r_a = 32'h12345678; s_stb_a = 2'b01;
    tick;
    for (int i = 0; i < 8; i++) begin
      check("t5_m_stb_held", m_stb_a, 1'b1);
      check("t5_no_err_yet", s_err_a, 2'b00);
      tick;
    end
    check("t5_m_stb_drop", m_stb_a, 1'b0);
    check("t5_s_err", s_err_a, 2'b01);
    check("t5_no_ack", s_ack_a, 2'b00);
    check("t5_s_dat_r", s_dat_r_a, 32'h0);
    s_stb_a = 2'b00;
    tick;
    check("t5_err_pulse", s_err_a, 2'b00);

    // 6: ack on the final watchdog cycle wins
    m_dat_r_a = 32'hCAFEF00D; s_stb_a = 2'b10;
    tick;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) ack_a = 1'b1;
      tick;
    end
    check("t6_s_ack", s_ack_a, 2'b10);
    check("t6_s_err", s_err_a, 2'b00);
    check("t6_s_dat_r", s_dat_r_a, 32'hCAFEF00D);
    ack_a = 1'b0; s_stb_a = 2'b00;
    tick;
`else
    // 5: no watchdog, request is held indefinitely
    s_stb_a = 2'b01;
    tick;
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (m_stb_a !== 1'b1 || s_err_a !== 2'b00 || s_ack_a !== 2'b00) ok = 1'b0;
      tick;
    end
    check("t5_held_1000", ok, 1'b1);
    check("t5_no_err", s_err_a, 2'b00);
    ack_a = 1'b1;
    tick;
    check("t5_late_ack", s_ack_a, 2'b01);
    ack_a = 1'b0; s_stb_a = 2'b00;
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
